// File: rtl/identity_sweep_checker.sv
// Sweeps every N_IN-bit vector onto stim and checks N_PAIRS lhs/rhs identity pairs per vector.
// Optional per-compare truth-row logging is enabled by defining TRUTH_LOG_EN.
module identity_sweep_checker #(
    parameter int N_IN    = 2,
    parameter int N_PAIRS = 4,
    parameter int SETTLE  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [N_IN-1:0]    stim,
    input  logic [N_PAIRS-1:0] lhs,
    input  logic [N_PAIRS-1:0] rhs,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [N_IN:0]      mismatch_cnt,
    output logic [N_IN-1:0]    first_fail_vec,
    output logic [N_PAIRS-1:0] first_fail_mask,
    output logic               log_valid,
    output logic [N_IN-1:0]    log_vec,
    output logic [N_PAIRS-1:0] log_lhs
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_COMPARE = 2'd2;
    localparam logic [1:0] S_FINISH  = 2'd3;

    localparam logic [3:0]      RELOAD   = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    logic [1:0]         state;
    logic [3:0]         settle_cnt;
    logic [N_PAIRS-1:0] diff;

    assign diff = lhs ^ rhs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            settle_cnt      <= '0;
            stim            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            mismatch_cnt    <= '0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        stim            <= '0;
                        settle_cnt      <= RELOAD;
                        mismatch_cnt    <= '0;
                        first_fail_vec  <= '0;
                        first_fail_mask <= '0;
                        pass            <= 1'b0;
                        busy            <= 1'b1;
                        state           <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_COMPARE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_COMPARE: begin
                    if (diff != '0) begin
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                        if (mismatch_cnt == '0) begin
                            first_fail_vec  <= stim;
                            first_fail_mask <= diff;
                        end
                    end
                    if (stim == LAST_VEC) begin
                        // pass folds in this last vector, whose count update lands in the same edge
                        done  <= 1'b1;
                        pass  <= (mismatch_cnt == '0) && (diff == '0);
                        state <= S_FINISH;
                    end else begin
                        stim       <= stim + 1'b1;
                        settle_cnt <= RELOAD;
                        state      <= S_SETTLE;
                    end
                end
                S_FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef TRUTH_LOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_valid <= 1'b0;
            log_vec   <= '0;
            log_lhs   <= '0;
        end else begin
            log_valid <= (state == S_COMPARE);
            if (state == S_COMPARE) begin
                log_vec <= stim;
                log_lhs <= lhs;
            end
        end
    end
`else
    assign log_valid = 1'b0;
    assign log_vec   = '0;
    assign log_lhs   = '0;
`endif

endmodule

// File: tb/tb_identity_sweep_checker.sv
// Bench for identity_sweep_checker: two instances (SETTLE=1 and SETTLE=2) checked every cycle
// against a timeline model, plus directed sweeps with literal expectations and random traffic.
module tb_identity_sweep_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    int         mode;
    logic [3:0] rm [4];

    logic [1:0] stim_d  [2];
    logic [3:0] lhs_d   [2];
    logic [3:0] rhs_d   [2];
    logic       busy_d  [2];
    logic       done_d  [2];
    logic       pass_d  [2];
    logic [2:0] mm_d    [2];
    logic [1:0] ffv_d   [2];
    logic [3:0] ffm_d   [2];
    logic       lv_d    [2];
    logic [1:0] lvec_d  [2];
    logic [3:0] llhs_d  [2];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Blocks under test: a = v[1], b = v[0]
    function automatic logic [3:0] lhs_of(input logic [1:0] v);
        logic a, b;
        a = v[1]; b = v[0];
        return {a | b, a & b, ~(a | b), ~(a & b)};
    endfunction

    function automatic logic [3:0] rhs_of(input int m, input logic [1:0] v, input logic [3:0] msk);
        logic a, b;
        logic [3:0] r;
        a = v[1]; b = v[0];
        r = {~(~a & ~b), ~(~a | ~b), ~a & ~b, ~a | ~b};
        case (m)
            1: r[0] = a & b;
            2: r[1] = (~a & ~b) | (a & b);
            3: r = r ^ msk;
            default: ;
        endcase
        return r;
    endfunction

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    assign lhs_d[0] = lhs_of(stim_d[0]);
    assign rhs_d[0] = rhs_of(mode, stim_d[0], rm[stim_d[0]]);
    assign lhs_d[1] = lhs_of(stim_d[1]);
    assign rhs_d[1] = rhs_of(mode, stim_d[1], rm[stim_d[1]]);

    identity_sweep_checker #(.N_IN(2), .N_PAIRS(4), .SETTLE(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim_d[0]),
        .lhs(lhs_d[0]), .rhs(rhs_d[0]), .busy(busy_d[0]), .done(done_d[0]),
        .pass(pass_d[0]), .mismatch_cnt(mm_d[0]), .first_fail_vec(ffv_d[0]),
        .first_fail_mask(ffm_d[0]), .log_valid(lv_d[0]), .log_vec(lvec_d[0]),
        .log_lhs(llhs_d[0])
    );

    identity_sweep_checker #(.N_IN(2), .N_PAIRS(4), .SETTLE(2)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim_d[1]),
        .lhs(lhs_d[1]), .rhs(rhs_d[1]), .busy(busy_d[1]), .done(done_d[1]),
        .pass(pass_d[1]), .mismatch_cnt(mm_d[1]), .first_fail_vec(ffv_d[1]),
        .first_fail_mask(ffm_d[1]), .log_valid(lv_d[1]), .log_vec(lvec_d[1]),
        .log_lhs(llhs_d[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: t counts cycles since the accepted start; vector v occupies cycles
    // v*(S+1) .. v*(S+1)+S and is compared in its last cycle.
    int         t_m    [2];
    logic       busy_m [2];
    logic       done_m [2];
    logic       pass_m [2];
    int         mm_m   [2];
    logic [1:0] stim_m [2];
    logic [1:0] ffv_m  [2];
    logic [3:0] ffm_m  [2];
    logic       lv_m   [2];
    logic [1:0] lvec_m [2];
    logic [3:0] llhs_m [2];

    always @(posedge clk or negedge rst_n) begin
        int s, v;
        logic [3:0] d;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                t_m[i] = 0; busy_m[i] = 0; done_m[i] = 0; pass_m[i] = 0; mm_m[i] = 0;
                stim_m[i] = 0; ffv_m[i] = 0; ffm_m[i] = 0;
                lv_m[i] = 0; lvec_m[i] = 0; llhs_m[i] = 0;
            end else begin
                lv_m[i] = 0;
                if (!busy_m[i]) begin
                    if (start) begin
                        busy_m[i] = 1; t_m[i] = 0; mm_m[i] = 0; pass_m[i] = 0;
                        ffv_m[i] = 0; ffm_m[i] = 0; stim_m[i] = 0;
                    end
                end else if (done_m[i]) begin
                    busy_m[i] = 0;
                    done_m[i] = 0;
                end else begin
                    s = settle_of(i);
                    v = t_m[i] / (s + 1);
                    if (t_m[i] % (s + 1) == s) begin
                        d = lhs_of(2'(v)) ^ rhs_of(mode, 2'(v), rm[v]);
                        lv_m[i] = 1; lvec_m[i] = 2'(v); llhs_m[i] = lhs_of(2'(v));
                        if (d != 0) begin
                            if (mm_m[i] == 0) begin ffv_m[i] = 2'(v); ffm_m[i] = d; end
                            mm_m[i]++;
                        end
                        if (v == 3) begin
                            done_m[i] = 1;
                            pass_m[i] = (mm_m[i] == 0);
                        end else begin
                            stim_m[i] = 2'(v + 1);
                        end
                    end
                    t_m[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("stim%0d", i), int'(stim_d[i]), int'(stim_m[i]));
            chk($sformatf("busy%0d", i), int'(busy_d[i]), int'(busy_m[i]));
            chk($sformatf("done%0d", i), int'(done_d[i]), int'(done_m[i]));
            chk($sformatf("pass%0d", i), int'(pass_d[i]), int'(pass_m[i]));
            chk($sformatf("mismatch_cnt%0d", i), int'(mm_d[i]), mm_m[i]);
            chk($sformatf("first_fail_vec%0d", i), int'(ffv_d[i]), int'(ffv_m[i]));
            chk($sformatf("first_fail_mask%0d", i), int'(ffm_d[i]), int'(ffm_m[i]));
`ifdef TRUTH_LOG_EN
            chk($sformatf("log_valid%0d", i), int'(lv_d[i]), int'(lv_m[i]));
            chk($sformatf("log_vec%0d", i), int'(lvec_d[i]), int'(lvec_m[i]));
            chk($sformatf("log_lhs%0d", i), int'(llhs_d[i]), int'(llhs_m[i]));
`else
            chk($sformatf("log_valid%0d", i), int'(lv_d[i]), 0);
            chk($sformatf("log_vec%0d", i), int'(lvec_d[i]), 0);
            chk($sformatf("log_lhs%0d", i), int'(llhs_d[i]), 0);
`endif
        end
    end

    // Truth-log capture for the SETTLE=2 instance
    int         ncyc = 0;
    bit         log_cap = 0;
    int         log_t   [$];
    logic [1:0] log_v   [$];
    logic [3:0] log_l   [$];
    always @(negedge clk) begin
        ncyc++;
        if (log_cap && lv_d[1]) begin
            log_t.push_back(ncyc);
            log_v.push_back(lvec_d[1]);
            log_l.push_back(llhs_d[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy_d[0] && !busy_d[1]) break;
        end
        if (k == 100) chk("idle_timeout", 1, 0);
        tick();
    endtask

    // Pulses start; returns negedge index of first done per instance (-1 if none)
    task automatic sweep(output int lat0, output int lat1);
        lat0 = -1; lat1 = -1;
        start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_d[0] && lat0 < 0) lat0 = k;
            if (done_d[1] && lat1 < 0) lat1 = k;
            if (lat0 >= 0 && lat1 >= 0) break;
            @(posedge clk);
            #2;
            start = 1'b0;
        end
        start = 1'b0;
        wait_idle();
    endtask

    task automatic check_results(input string nm, input int mm, input int ps,
                                 input int fv, input int fm);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_mm%0d", nm, i), int'(mm_d[i]), mm);
            chk($sformatf("%s_pass%0d", nm, i), int'(pass_d[i]), ps);
            chk($sformatf("%s_ffv%0d", nm, i), int'(ffv_d[i]), fv);
            chk($sformatf("%s_ffm%0d", nm, i), int'(ffm_d[i]), fm);
        end
    endtask

    initial begin
        int l0, l1, dcnt, b10, b11;
        start = 1'b0;
        mode  = 0;
        for (int j = 0; j < 4; j++) rm[j] = 4'h0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_results("reset", 0, 0, 0, 0);
        chk("reset_busy", int'(busy_d[0]), 0);
        rst_n = 1'b1;
        tick();

        // Matching identities: clean sweep, fixed latency
        mode = 0;
        sweep(l0, l1);
        chk("t1_latency_s1", l0, 9);
        chk("t1_latency_s2", l1, 13);
        check_results("t1", 0, 1, 0, 0);

        // rhs[0] = a&b mismatches NAND on every vector
        mode = 1;
        sweep(l0, l1);
        check_results("t2", 4, 0, 0, 1);

        // rhs[1] wrong only at a=b=1
        mode = 2;
        sweep(l0, l1);
        check_results("t3", 1, 0, 3, 2);

        // start held high: one done, FINISH ignores start, re-accept only from IDLE
        mode = 0;
        start = 1'b1;
        dcnt = 0; b10 = -1; b11 = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_d[0]) dcnt++;
            if (k == 10) b10 = int'(busy_d[0]);
            if (k == 11) b11 = int'(busy_d[0]);
            @(posedge clk);
            #2;
        end
        start = 1'b0;
        chk("t4_done_count", dcnt, 1);
        chk("t4_busy_idle_gap", b10, 0);
        chk("t4_busy_restart", b11, 1);
        wait_idle();

        // Asynchronous reset mid-sweep
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t5_stim%0d", i), int'(stim_d[i]), 0);
            chk($sformatf("t5_busy%0d", i), int'(busy_d[i]), 0);
            chk($sformatf("t5_done%0d", i), int'(done_d[i]), 0);
            chk($sformatf("t5_mm%0d", i), int'(mm_d[i]), 0);
            chk($sformatf("t5_ffm%0d", i), int'(ffm_d[i]), 0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        mode = 0;
        sweep(l0, l1);
        chk("t5_latency_s1", l0, 9);
        check_results("t5", 0, 1, 0, 0);

        // Truth log on the SETTLE=2 instance
        log_t.delete(); log_v.delete(); log_l.delete();
        log_cap = 1;
        sweep(l0, l1);
        log_cap = 0;
`ifdef TRUTH_LOG_EN
        chk("t6_strobes", log_t.size(), 4);
        if (log_t.size() == 4) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("t6_vec%0d", j), int'(log_v[j]), j);
                chk($sformatf("t6_nand%0d", j), int'(log_l[j][0]), (j == 3) ? 0 : 1);
                if (j > 0) chk($sformatf("t6_gap%0d", j), log_t[j] - log_t[j-1], 3);
            end
        end
`else
        chk("t6_no_strobes", log_t.size(), 0);
`endif

        // Random traffic: start, fault mode, masks and occasional resets
        for (int n = 0; n < 600; n++) begin
            start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) mode = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) rm[$urandom_range(0, 3)] = 4'($urandom);
            if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end
        start = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
